// File: rtl/hash_mem_pkg.sv
// -----------------------------------------------------------------------------
// hash_mem_pkg
//   Shared types and default sizing for the hash memory responder.
//   - state_t : responder FSM states
//   - word_t  : 32-bit RAM / stream word
//   - DEF_*   : default parameter values used by the responder and its RAM
// -----------------------------------------------------------------------------
package hash_mem_pkg;

  typedef enum logic [2:0] {
    LOAD,
    START,
    RUN,
    DRAIN_RD,
    DRAIN_OUT
  } state_t;

  typedef logic [31:0] word_t;

  localparam int DEF_DEPTH     = 64;
  localparam int DEF_MSG_WORDS = 19;
  localparam int DEF_OUT_WORDS = 16;
  localparam int DEF_MSG_BASE  = 0;
  localparam int DEF_OUT_BASE  = 32;

endpackage

// File: rtl/hash_word_ram.sv
// -----------------------------------------------------------------------------
// hash_word_ram
//   DEPTH x 32 word RAM, one address shared by the read and write port.
//   Registered read (1-cycle latency), write-first on a same-cycle access.
//   Addresses >= DEPTH read as 0 and writes to them are dropped (no wrap).
// Ports:
//   clk    in   clock
//   we     in   write enable
//   re     in   read enable; rdata holds its value while low
//   addr   in   16-bit word address
//   wdata  in   write data
//   rdata  out  registered read data
// -----------------------------------------------------------------------------
module hash_word_ram
  import hash_mem_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic        clk,
  input  logic        we,
  input  logic        re,
  input  logic [15:0] addr,
  input  word_t       wdata,
  output word_t       rdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  word_t          mem [DEPTH];
  logic           in_range;
  logic [AW-1:0]  idx;

  // Full 16-bit compare so high addresses never alias into the array.
  assign in_range = (addr < 16'(DEPTH));
  assign idx      = addr[AW-1:0];

  always_ff @(posedge clk) begin
    if (we && in_range) begin
      mem[idx] <= wdata;
    end
    if (re) begin
      if (!in_range) begin
        rdata <= '0;
      end else if (we) begin
        rdata <= wdata;
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/hash_mem_responder.sv
// -----------------------------------------------------------------------------
// hash_mem_responder
//   Memory-side target for the bitcoin_hash core. The host streams MSG_WORDS
//   message words into RAM, the block pulses start, serves the hasher's memory
//   port until done, then streams OUT_WORDS result words back to the host.
//   Optional build macro: HASH_MEM_ERR_EN adds a sticky 'err' output flagging
//   out-of-range accesses or message-region writes while the hasher runs.
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   start                         one-cycle pulse to the hasher
//   message_addr, output_addr     constant region base addresses
//   done                          hasher completion pulse (honoured in RUN)
//   mem_we/mem_addr/mem_write_data/mem_read_data   hasher memory port
//   in_valid/in_ready/in_data     host load stream
//   out_valid/out_ready/out_data/out_last           result drain stream
//   busy                          high outside LOAD
//   err (HASH_MEM_ERR_EN only)    sticky access error
// -----------------------------------------------------------------------------
module hash_mem_responder
  import hash_mem_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int MSG_WORDS = DEF_MSG_WORDS,
  parameter int OUT_WORDS = DEF_OUT_WORDS,
  parameter int MSG_BASE  = DEF_MSG_BASE,
  parameter int OUT_BASE  = DEF_OUT_BASE
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        start,
  output logic [15:0] message_addr,
  output logic [15:0] output_addr,
  input  logic        done,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  word_t       mem_write_data,
  output word_t       mem_read_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  word_t       in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output word_t       out_data,
  output logic        out_last,
  output logic        busy
`ifdef HASH_MEM_ERR_EN
  ,
  output logic        err
`endif
);

  // Elaboration-time sanity checks on the memory map.
  if (MSG_BASE + MSG_WORDS > DEPTH) begin : g_chk_msg
    $error("message region exceeds DEPTH");
  end
  if (OUT_BASE + OUT_WORDS > DEPTH) begin : g_chk_out
    $error("result region exceeds DEPTH");
  end
  if (!((MSG_BASE + MSG_WORDS <= OUT_BASE) || (OUT_BASE + OUT_WORDS <= MSG_BASE))) begin : g_chk_ovl
    $error("message and result regions overlap");
  end

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic        ready_reg;     // keeps in_ready low for the first cycle out of reset
  logic        rd_owner_reg;  // last RAM read was issued on behalf of the hasher
  word_t       held_reg;      // hasher-visible read data preserved across drain reads

  logic        ram_we, ram_re;
  logic [15:0] ram_addr;
  word_t       ram_wdata, ram_rdata;

  logic        load_fire, last_out;

  assign load_fire = (state_reg == LOAD) && ready_reg && in_valid;
  assign last_out  = (cnt_reg == 16'(OUT_WORDS - 1));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = in_data;
    case (state_reg)
      LOAD: begin
        ram_addr = 16'(MSG_BASE) + cnt_reg;
        if (load_fire) begin
          ram_we = 1'b1;
          if (cnt_reg == 16'(MSG_WORDS - 1)) begin
            state_next = START;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 16'd1;
          end
        end
      end
      START: begin
        state_next = RUN;
      end
      RUN: begin
        ram_addr  = mem_addr;
        ram_we    = mem_we;
        ram_wdata = mem_write_data;
        ram_re    = 1'b1;
        if (done) begin
          state_next = DRAIN_RD;
          cnt_next   = '0;
        end
      end
      DRAIN_RD: begin
        ram_addr   = 16'(OUT_BASE) + cnt_reg;
        ram_re     = 1'b1;
        state_next = DRAIN_OUT;
      end
      DRAIN_OUT: begin
        // RAM read port idles here, so ram_rdata stays stable under backpressure.
        if (out_ready) begin
          if (last_out) begin
            state_next = LOAD;
            cnt_next   = '0;
          end else begin
            cnt_next   = cnt_reg + 16'd1;
            state_next = DRAIN_RD;
          end
        end
      end
      default: begin
        state_next = LOAD;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= LOAD;
      cnt_reg      <= '0;
      ready_reg    <= 1'b0;
      rd_owner_reg <= 1'b0;
      held_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      ready_reg    <= 1'b1;
      rd_owner_reg <= (state_reg == RUN);
      if (rd_owner_reg) begin
        held_reg <= ram_rdata;
      end
    end
  end

  hash_word_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign start         = (state_reg == START);
  assign message_addr  = 16'(MSG_BASE);
  assign output_addr   = 16'(OUT_BASE);
  assign in_ready      = (state_reg == LOAD) && ready_reg;
  assign busy          = (state_reg != LOAD);
  assign out_valid     = (state_reg == DRAIN_OUT);
  assign out_last      = out_valid && last_out;
  assign out_data      = out_valid ? ram_rdata : '0;
  // Outside RUN the hasher keeps seeing its own last read, not drain reads.
  assign mem_read_data = rd_owner_reg ? ram_rdata : held_reg;

`ifdef HASH_MEM_ERR_EN
  logic err_reg;
  logic bad_access;

  // Offset subtraction wraps for addresses below MSG_BASE, so one compare
  // covers both region bounds.
  assign bad_access = (state_reg == RUN) &&
                      ((mem_addr >= 16'(DEPTH)) ||
                       (mem_we && ((mem_addr - 16'(MSG_BASE)) < 16'(MSG_WORDS))));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_reg <= 1'b0;
    end else if ((state_next == START) && (state_reg != START)) begin
      err_reg <= 1'b0;
    end else if (bad_access) begin
      err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`endif

endmodule

// File: tb/tb_hash_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_hash_mem_responder
//   Directed bench for hash_mem_responder: reset values, message load and
//   start pulse, hasher reads/writes, result drain with backpressure, reset
//   during RUN and (with HASH_MEM_ERR_EN) the sticky error flag.
// -----------------------------------------------------------------------------
module tb_hash_mem_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] message_addr, output_addr;
  logic        done;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data, mem_read_data;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data;
  logic        busy;
`ifdef HASH_MEM_ERR_EN
  logic        err;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int start_cnt = 0;

  always #5 clk = ~clk;

  hash_mem_responder dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .message_addr   (message_addr),
    .output_addr    (output_addr),
    .done           (done),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .busy           (busy)
`ifdef HASH_MEM_ERR_EN
    ,
    .err            (err)
`endif
  );

  // Counts start pulses, sampled mid-cycle.
  always @(negedge clk) if (start) start_cnt++;

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; done = 1'b0;
    mem_we = 1'b0; mem_addr = '0; mem_write_data = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL reset_start got=%0b exp=0", start); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    n_cmp++; if ({out_valid, out_last} !== 2'b00) begin n_bad++; $display("FAIL reset_out_flags got=%b exp=00", {out_valid, out_last}); end
    n_cmp++; if (out_data !== 32'h0) begin n_bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    n_cmp++; if (mem_read_data !== 32'h0) begin n_bad++; $display("FAIL reset_rd_data got=%h exp=0", mem_read_data); end
    n_cmp++; if (message_addr !== 16'd0) begin n_bad++; $display("FAIL message_addr got=%0d exp=0", message_addr); end
    n_cmp++; if (output_addr !== 16'd32) begin n_bad++; $display("FAIL output_addr got=%0d exp=32", output_addr); end
`ifdef HASH_MEM_ERR_EN
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%0b exp=0", err); end
`endif
    reset_n = 1'b1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL first_cycle_in_ready got=%0b exp=0", in_ready); end
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_in_ready got=%0b exp=1", in_ready); end
    $display("reset: done");
  endtask

  // Loads words base+1 .. base+19 with in_valid held high; ends in RUN.
  task automatic test_load(input logic [31:0] base);
    int s0;
    int wait_cyc;
    logic [31:0] exp_word;
    s0 = start_cnt;
    in_valid = 1'b1;
    for (int k = 0; k < 19; k++) begin
      in_data = base + 32'(k + 1);
      wait_cyc = 0;
      while (!in_ready && wait_cyc < 10) begin @(negedge clk); wait_cyc++; end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL load_ready_timeout word=%0d got=%0b exp=1", k, in_ready); end
      if (k == 18) begin
        n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL early_start got=%0b exp=0", start); end
      end
      $display("load word %0d data=%h", k, in_data);
      @(negedge clk);
    end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL in_ready_after_load got=%0b exp=0", in_ready); end
    n_cmp++; if (start !== 1'b1) begin n_bad++; $display("FAIL start_pulse got=%0b exp=1", start); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_start got=%0b exp=1", busy); end
`ifdef HASH_MEM_ERR_EN
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_clear_at_start got=%0b exp=0", err); end
`endif
    in_data = 32'hDEAD_BEEF;
    @(negedge clk);
    n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL start_width got=%0b exp=0", start); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL in_ready_run got=%0b exp=0", in_ready); end
    n_cmp++; if (start_cnt - s0 !== 1) begin n_bad++; $display("FAIL start_count got=%0d exp=1", start_cnt - s0); end
    in_valid = 1'b0;
    for (int k = 0; k < 19; k++) begin
      exp_word = base + 32'(k + 1);
      n_cmp++; if (dut.u_ram.mem[k] !== exp_word) begin n_bad++; $display("FAIL backdoor_msg addr=%0d got=%h exp=%h", k, dut.u_ram.mem[k], exp_word); end
    end
  endtask

  task automatic test_run_reads();
    mem_addr = 16'd5; mem_we = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_read_data !== 32'h6) begin n_bad++; $display("FAIL read_addr5 got=%h exp=00000006", mem_read_data); end
`ifdef HASH_MEM_ERR_EN
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_before_bad_write got=%0b exp=0", err); end
    mem_addr = 16'd3; mem_we = 1'b1; mem_write_data = 32'h33;
    @(negedge clk);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_msg_write got=%0b exp=1", err); end
`endif
    mem_addr = 16'd40; mem_we = 1'b1; mem_write_data = 32'h5555_AAAA;
    @(negedge clk);
    n_cmp++; if (mem_read_data !== 32'h5555_AAAA) begin n_bad++; $display("FAIL write_first got=%h exp=5555aaaa", mem_read_data); end
    mem_we = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_read_data !== 32'h5555_AAAA) begin n_bad++; $display("FAIL readback_40 got=%h exp=5555aaaa", mem_read_data); end
    mem_addr = 16'd70; mem_we = 1'b1; mem_write_data = 32'h1234_5678;
    @(negedge clk);
    n_cmp++; if (mem_read_data !== 32'h0) begin n_bad++; $display("FAIL read_addr70 got=%h exp=0", mem_read_data); end
    mem_addr = 16'd64; mem_we = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_read_data !== 32'h0) begin n_bad++; $display("FAIL read_addr64 got=%h exp=0", mem_read_data); end
    mem_addr = 16'd6;
    @(negedge clk);
    n_cmp++; if (mem_read_data !== 32'h7) begin n_bad++; $display("FAIL no_wrap_addr6 got=%h exp=00000007", mem_read_data); end
    $display("run reads: done");
  endtask

  task automatic test_drain();
    int got, stall, cyc, s0;
    logic [31:0] exp_word;
    logic exp_last;
    for (int i = 0; i < 16; i++) begin
      mem_addr = 16'(32 + i); mem_we = 1'b1; mem_write_data = 32'hA000_0000 + 32'(i);
      @(negedge clk);
    end
    n_cmp++; if (mem_read_data !== 32'hA000_000F) begin n_bad++; $display("FAIL last_result_write got=%h exp=a000000f", mem_read_data); end
    mem_we = 1'b0; mem_addr = 16'd5; done = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    done = 1'b0; mem_addr = 16'd7;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL drain_rd_valid got=%0b exp=0", out_valid); end
    n_cmp++; if (mem_read_data !== 32'h6) begin n_bad++; $display("FAIL rd_data_at_done got=%h exp=00000006", mem_read_data); end
    got = 0; stall = 0; cyc = 0;
    while (got < 16 && cyc < 200) begin
      @(negedge clk); cyc++;
      if (out_valid) begin
        exp_word = 32'hA000_0000 + 32'(got);
        if (got == 3 && stall < 5) begin
          out_ready = 1'b0; stall++;
          n_cmp++; if (out_data !== exp_word) begin n_bad++; $display("FAIL stall_data cyc=%0d got=%h exp=%h", stall, out_data, exp_word); end
        end else begin
          out_ready = 1'b1;
          exp_last = (got == 15);
          n_cmp++; if (out_data !== exp_word) begin n_bad++; $display("FAIL drain_data word=%0d got=%h exp=%h", got, out_data, exp_word); end
          n_cmp++; if (out_last !== exp_last) begin n_bad++; $display("FAIL drain_last word=%0d got=%0b exp=%0b", got, out_last, exp_last); end
          $display("drain word %0d data=%h last=%0b", got, out_data, out_last);
          got++;
        end
      end
    end
    n_cmp++; if (got !== 16) begin n_bad++; $display("FAIL drain_timeout got=%0d words exp=16", got); end
    n_cmp++; if (cyc !== 36) begin n_bad++; $display("FAIL drain_cycles got=%0d exp=36", cyc); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_after_drain got=%0b exp=0", busy); end
    n_cmp++; if ({out_valid, out_last} !== 2'b00) begin n_bad++; $display("FAIL out_after_drain got=%b exp=00", {out_valid, out_last}); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL in_ready_after_drain got=%0b exp=1", in_ready); end
    n_cmp++; if (mem_read_data !== 32'h6) begin n_bad++; $display("FAIL rd_data_held got=%h exp=00000006", mem_read_data); end
`ifdef HASH_MEM_ERR_EN
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky got=%0b exp=1", err); end
`endif
    s0 = start_cnt;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || start_cnt != s0) begin n_bad++; $display("FAIL done_in_load busy=%0b starts=%0d exp busy=0 starts=0", busy, start_cnt - s0); end
  endtask

  task automatic test_reset_mid_run();
    int s0;
    test_load(32'h100);
    mem_addr = 16'd5;
    @(negedge clk);
    n_cmp++; if (mem_read_data !== 32'h106) begin n_bad++; $display("FAIL run2_read got=%h exp=00000106", mem_read_data); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL async_busy got=%0b exp=0", busy); end
    n_cmp++; if (mem_read_data !== 32'h0) begin n_bad++; $display("FAIL async_rd_data got=%h exp=0", mem_read_data); end
    n_cmp++; if ({start, in_ready, out_valid} !== 3'b000) begin n_bad++; $display("FAIL async_flags got=%b exp=000", {start, in_ready, out_valid}); end
    @(negedge clk);
    reset_n = 1'b1;
    s0 = start_cnt;
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || start_cnt != s0) begin n_bad++; $display("FAIL done_after_reset busy=%0b starts=%0d exp busy=0 starts=0", busy, start_cnt - s0); end
    test_load(32'h200);
    $display("reset mid-run: done");
  endtask

  initial begin
    test_reset();
    test_load(32'h0);
    test_run_reads();
    test_drain();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
